// File: rtl/jt49_noise_pkg.sv
// jt49_noise_pkg
// Shared definitions for the JT49 noise checker and the noise generator model:
// window width, LFSR tap positions and the checker state encoding.
package jt49_noise_pkg;

   localparam int WIN_W = 17;
   localparam int TAP_A = 0;
   localparam int TAP_B = 3;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } nchk_state_e;

endpackage

// File: rtl/jt49_lfsr17_pred.sv
// jt49_lfsr17_pred
// Purely combinational next-bit predictor for the 17-bit noise LFSR.
// Ports:
//   i_win  [16:0] window, bit 0 oldest, bit 16 newest
//   o_pred        predicted next bit
module jt49_lfsr17_pred
   import jt49_noise_pkg::*;
(
   input  logic [WIN_W-1:0] i_win,
   output logic             o_pred
);

   // An all-zero window would lock the LFSR up, so it predicts 1 instead.
   assign o_pred = i_win[TAP_A] ^ i_win[TAP_B] ^ (i_win == '0);

endmodule

// File: rtl/jt49_noise_chk.sv
// jt49_noise_chk
// Watches the received JT49 noise stream, synchronises a 17-bit window to it
// and then checks every following bit against the LFSR prediction.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cen             clock enable, nothing changes while low
//   sample          one received noise step (qualified by cen)
//   noise           received noise level, stored bit is ~noise
//   locked          high while in LOCK
//   state [1:0]     HUNT=0, VERIFY=1, LOCK=2
//   err             one-clk pulse on a misprediction in LOCK
//   err_cnt [15:0]  saturating count of LOCK mispredictions
//
// state  | meaning
// HUNT   | filling the window with 17 samples, no checking
// VERIFY | checking, waiting for LOCK_N consecutive matches
// LOCK   | locked, mispredictions flagged; LOSS_N in a row drop back to HUNT
module jt49_noise_chk
   import jt49_noise_pkg::*;
#(
   parameter int LOCK_N = 17,
   parameter int LOSS_N = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        sample,
   input  logic        noise,
   output logic        locked,
   output logic [1:0]  state,
   output logic        err,
   output logic [15:0] err_cnt
);

   localparam logic [4:0] FILL_LAST = 5'(WIN_W - 1);
   localparam logic [5:0] GOOD_LAST = 6'(LOCK_N - 1);
   localparam logic [3:0] BAD_LAST  = 4'(LOSS_N - 1);

   nchk_state_e      r_state, w_state_nxt;
   logic [WIN_W-1:0] r_win;
   logic [4:0]       r_fill, w_fill_nxt;
   logic [5:0]       r_good, w_good_nxt;
   logic [3:0]       r_bad, w_bad_nxt;
   logic             r_err, w_err_nxt;
   logic             r_locked;
   logic [15:0]      r_err_cnt;

   logic w_acc;
   logic w_d;
   logic w_pred;
   logic w_match;

   assign w_acc   = cen & sample;
   assign w_d     = ~noise;
   assign w_match = (w_d == w_pred);

   jt49_lfsr17_pred u_pred (
      .i_win  (r_win),
      .o_pred (w_pred)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_err_nxt   = 1'b0;
      if (w_acc) begin
         case (r_state)
            ST_HUNT: begin
               if (r_fill == FILL_LAST) begin
                  w_state_nxt = ST_VERIFY;
                  w_fill_nxt  = '0;
                  w_good_nxt  = '0;
               end else begin
                  w_fill_nxt = r_fill + 5'd1;
               end
            end
            ST_VERIFY: begin
               if (!w_match) begin
                  w_good_nxt = '0;
               end else if (r_good == GOOD_LAST) begin
                  w_state_nxt = ST_LOCK;
                  w_good_nxt  = '0;
                  w_bad_nxt   = '0;
               end else begin
                  w_good_nxt = r_good + 6'd1;
               end
            end
            ST_LOCK: begin
               if (w_match) begin
                  w_bad_nxt = '0;
               end else begin
                  w_err_nxt = 1'b1;
                  if (r_bad == BAD_LAST) begin
                     w_state_nxt = ST_HUNT;
                     w_fill_nxt  = '0;
                     w_good_nxt  = '0;
                     w_bad_nxt   = '0;
                  end else begin
                     w_bad_nxt = r_bad + 4'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_HUNT;
               w_fill_nxt  = '0;
               w_good_nxt  = '0;
               w_bad_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_HUNT;
         r_fill   <= '0;
         r_good   <= '0;
         r_bad    <= '0;
         r_locked <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_fill   <= w_fill_nxt;
         r_good   <= w_good_nxt;
         r_bad    <= w_bad_nxt;
         r_locked <= (w_state_nxt == ST_LOCK);
      end
   end

   // err is refreshed on every edge so it is a single-clk pulse and is
   // cleared by any edge that does not carry a LOCK misprediction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_err_nxt;
         if (w_err_nxt && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win <= '0;
      end else if (w_acc) begin
         r_win <= {w_d, r_win[WIN_W-1:1]};
      end
   end

   assign locked  = r_locked;
   assign state   = r_state;
   assign err     = r_err;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_jt49_noise_chk.sv
// tb_jt49_noise_chk
// Self-checking bench: a behavioural reference model of the checker produces
// the expected outputs for every driven cycle; they go through a queue and are
// compared after the clock edge.
module tb_jt49_noise_chk;

   localparam int LOCK_N = 17;
   localparam int LOSS_N = 3;

   logic        clk;
   logic        rst;
   logic        cen;
   logic        sample;
   logic        noise;
   logic        locked;
   logic [1:0]  state;
   logic        err;
   logic [15:0] err_cnt;

   jt49_noise_chk #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
      .clk     (clk),
      .rst     (rst),
      .cen     (cen),
      .sample  (sample),
      .noise   (noise),
      .locked  (locked),
      .state   (state),
      .err     (err),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic        lk;
      logic        er;
      logic [15:0] ec;
      logic [16:0] w;
   } exp_t;

   exp_t q[$];

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   logic [16:0] m_w;
   int          m_state;
   int          m_fill;
   int          m_good;
   int          m_bad;
   logic        m_err;
   logic [15:0] m_ec;

   // noise generator
   logic [16:0] gen_w = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_w = '0; m_state = 0; m_fill = 0; m_good = 0; m_bad = 0;
      m_err = 1'b0; m_ec = '0;
   endtask

   task automatic model_step(input logic c, input logic s, input logic n);
      logic d, p, mis;
      m_err = 1'b0;
      if (c && s) begin
         d   = ~n;
         p   = m_w[0] ^ m_w[3] ^ (m_w == 17'd0);
         mis = (d != p);
         m_w = {d, m_w[16:1]};
         if (m_state == 0) begin
            m_fill++;
            if (m_fill == 17) begin m_state = 1; m_fill = 0; m_good = 0; end
         end else if (m_state == 1) begin
            if (mis) m_good = 0;
            else begin
               m_good++;
               if (m_good == LOCK_N) begin m_state = 2; m_good = 0; m_bad = 0; end
            end
         end else begin
            if (!mis) m_bad = 0;
            else begin
               m_err = 1'b1;
               if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
               m_bad++;
               if (m_bad == LOSS_N) begin m_state = 0; m_fill = 0; m_good = 0; m_bad = 0; end
            end
         end
      end
   endtask

   task automatic gen_adv(output logic b);
      b = gen_w[0] ^ gen_w[3] ^ (gen_w == 17'd0);
      gen_w = {b, gen_w[16:1]};
   endtask

   task automatic compare_all(input exp_t e);
      check("state",   32'(state),     32'(e.st));
      check("locked",  32'(locked),    32'(e.lk));
      check("err",     32'(err),       32'(e.er));
      check("err_cnt", 32'(err_cnt),   32'(e.ec));
      check("window",  32'(dut.r_win), 32'(e.w));
   endtask

   function automatic exp_t model_snap();
      exp_t e;
      e.st = 2'(m_state);
      e.lk = (m_state == 2);
      e.er = m_err;
      e.ec = m_ec;
      e.w  = m_w;
      return e;
   endfunction

   task automatic step(input logic c, input logic s, input logic n);
      exp_t e;
      @(negedge clk);
      cen = c; sample = s; noise = n;
      model_step(c, s, n);
      q.push_back(model_snap());
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         compare_all(e);
      end
   endtask

   task automatic clean();
      logic b;
      gen_adv(b);
      step(1'b1, 1'b1, ~b);
   endtask

   task automatic inv();
      logic b;
      gen_adv(b);
      step(1'b1, 1'b1, b);
   endtask

   // asserts rst between edges and checks the outputs clear without a clock
   task automatic pulse_reset();
      @(negedge clk);
      cen = 1'b0; sample = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      compare_all(model_snap());
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic b;
      rst = 1'b1; cen = 1'b0; sample = 1'b0; noise = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all(model_snap());
      @(negedge clk);
      rst = 1'b0;

      // clean generator stream, one sample per clk
      for (int i = 0; i < 10000; i++) begin
         clean();
         if (i == 15) check("hunt_at_16", 32'(state), 32'd0);
         if (i == 16) check("verify_at_17", 32'(state), 32'd1);
         if (i == 32) check("unlocked_at_33", 32'(locked), 32'd0);
         if (i == 33) check("locked_at_34", 32'(locked), 32'd1);
      end
      check("clean_err_cnt", 32'(err_cnt), 32'd0);

      // single inverted sample while locked
      inv();
      check("single_err_pulse", 32'(err), 32'd1);
      check("single_err_cnt", 32'(err_cnt), 32'd1);
      check("single_stay_lock", 32'(state), 32'd2);
      clean();
      check("err_deassert", 32'(err), 32'd0);

      // three consecutive inversions drop to HUNT, then relock
      pulse_reset();
      for (int i = 0; i < 34; i++) clean();
      check("relock_34", 32'(locked), 32'd1);
      inv(); inv(); inv();
      check("loss_state", 32'(state), 32'd0);
      check("loss_err_same_cycle", 32'(err), 32'd1);
      check("loss_err_cnt", 32'(err_cnt), 32'd3);
      for (int i = 0; i < 34; i++) clean();
      check("relock_after_loss", 32'(locked), 32'd1);

      // random cen / sample pattern, strobe sometimes held across cen cycles
      for (int i = 0; i < 400; i++) begin
         logic c, s;
         c = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 3) != 0);
         if (c && s) begin
            gen_adv(b);
            step(c, s, ~b);
         end else begin
            step(c, s, 1'($urandom_range(0, 1)));
         end
      end
      check("random_locked", 32'(locked), 32'd1);

      // err_cnt saturation
      @(negedge clk);
      cen = 1'b0; sample = 1'b0;
      force dut.r_err_cnt = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.r_err_cnt;
      m_ec = 16'hFFFE;
      @(posedge clk);
      #1;
      check("forced_err_cnt", 32'(err_cnt), 32'h0000FFFE);
      inv(); clean(); inv(); clean(); inv();
      check("sat_err_pulse", 32'(err), 32'd1);
      check("sat_err_cnt", 32'(err_cnt), 32'h0000FFFF);
      for (int i = 0; i < 4; i++) clean();

      // reset mid-LOCK, then full relock needed
      check("pre_reset_locked", 32'(locked), 32'd1);
      pulse_reset();
      for (int i = 0; i < 33; i++) clean();
      check("no_early_relock", 32'(locked), 32'd0);
      clean();
      check("relock_after_reset", 32'(locked), 32'd1);

      // cen low with strobes: window untouched
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

      // noise stuck high never locks
      pulse_reset();
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
      check("stuck_state_verify", 32'(state), 32'd1);
      check("stuck_not_locked", 32'(locked), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
